// File: rtl/fixed_pkg.sv
// Shared widths, palette mapping and the quarter-wave cosine table used by
// angle_color_unit.
package fixed_pkg;

  localparam int INT_BITS   = 16;
  localparam int FLOAT_BITS = 32;
  localparam int FRAC_BITS  = 16;
  localparam int PIXLW      = 12;

  // round(2^FRAC_BITS * cos(k deg)) using a Q30 Taylor series, elaboration only
  function automatic logic signed [FLOAT_BITS-1:0] cos_q16(input int k);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (longint'(k) * 64'sd3373259426 + 64'sd90) / 64'sd180;
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    sum  = term;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return FLOAT_BITS'(((sum <<< FRAC_BITS) + (64'sd1 <<< 29)) >>> 30);
  endfunction

  localparam logic signed [FLOAT_BITS-1:0] COS_TABLE [0:90] = '{
    cos_q16(0),  cos_q16(1),  cos_q16(2),  cos_q16(3),  cos_q16(4),
    cos_q16(5),  cos_q16(6),  cos_q16(7),  cos_q16(8),  cos_q16(9),
    cos_q16(10), cos_q16(11), cos_q16(12), cos_q16(13), cos_q16(14),
    cos_q16(15), cos_q16(16), cos_q16(17), cos_q16(18), cos_q16(19),
    cos_q16(20), cos_q16(21), cos_q16(22), cos_q16(23), cos_q16(24),
    cos_q16(25), cos_q16(26), cos_q16(27), cos_q16(28), cos_q16(29),
    cos_q16(30), cos_q16(31), cos_q16(32), cos_q16(33), cos_q16(34),
    cos_q16(35), cos_q16(36), cos_q16(37), cos_q16(38), cos_q16(39),
    cos_q16(40), cos_q16(41), cos_q16(42), cos_q16(43), cos_q16(44),
    cos_q16(45), cos_q16(46), cos_q16(47), cos_q16(48), cos_q16(49),
    cos_q16(50), cos_q16(51), cos_q16(52), cos_q16(53), cos_q16(54),
    cos_q16(55), cos_q16(56), cos_q16(57), cos_q16(58), cos_q16(59),
    cos_q16(60), cos_q16(61), cos_q16(62), cos_q16(63), cos_q16(64),
    cos_q16(65), cos_q16(66), cos_q16(67), cos_q16(68), cos_q16(69),
    cos_q16(70), cos_q16(71), cos_q16(72), cos_q16(73), cos_q16(74),
    cos_q16(75), cos_q16(76), cos_q16(77), cos_q16(78), cos_q16(79),
    cos_q16(80), cos_q16(81), cos_q16(82), cos_q16(83), cos_q16(84),
    cos_q16(85), cos_q16(86), cos_q16(87), cos_q16(88), cos_q16(89),
    cos_q16(90)
  };

  // Palette colour from coordinate bits [6:1]: R = x[6:3], G = y[6:3], B = {x[2:1], y[2:1]}
  function automatic logic [PIXLW-1:0] palette(input logic [5:0] xs, input logic [5:0] ys);
    return {xs[5:2], ys[5:2], xs[1:0], ys[1:0]};
  endfunction

endpackage

// File: rtl/angle_color_unit_cos_quarter_rom.sv
// Combinational cosine of a signed angle in [-180, 180], folded onto the
// 0..90 degree quarter-wave table.
module angle_color_unit_cos_quarter_rom
  import fixed_pkg::*;
(
  input  logic signed [INT_BITS-1:0]   ang,
  output logic signed [FLOAT_BITS-1:0] cos_val
);

  logic [INT_BITS-1:0] mag;
  logic [6:0]          idx;

  always_comb begin
    mag = ang[INT_BITS-1] ? INT_BITS'(-ang) : INT_BITS'(ang);
    if (mag <= INT_BITS'(90)) begin
      idx     = mag[6:0];
      cos_val = COS_TABLE[idx];
    end else begin
      idx     = 7'(INT_BITS'(180) - mag);
      cos_val = -COS_TABLE[idx];
    end
  end

endmodule

// File: rtl/angle_color_unit.sv
// Rotation angle register with circular wrap and registered Q16.16 cosine,
// plus colour-picker palette lookup and swatch/crosshair renderer.
module angle_color_unit
  import fixed_pkg::*;
#(
  parameter int ANG_MIN   = -180,
  parameter int ANG_MAX   = 179,
  parameter int PICK_SIZE = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ang_dec,
  input  logic                         ang_inc,
  output logic signed [INT_BITS-1:0]   ang,
  output logic signed [INT_BITS-1:0]   ang_prev,
  output logic signed [INT_BITS-1:0]   ang_next,
  output logic signed [FLOAT_BITS-1:0] cos_out,
  input  logic [INT_BITS-1:0]          cx,
  input  logic [INT_BITS-1:0]          cy,
  input  logic [INT_BITS-1:0]          sx,
  input  logic [INT_BITS-1:0]          sy,
  output logic [PIXLW-1:0]             color,
  output logic [PIXLW-1:0]             render
);

  localparam logic signed [INT_BITS-1:0]   A_MIN   = INT_BITS'(ANG_MIN);
  localparam logic signed [INT_BITS-1:0]   A_MAX   = INT_BITS'(ANG_MAX);
  localparam logic [INT_BITS-1:0]          PICK    = INT_BITS'(PICK_SIZE);
  localparam logic signed [FLOAT_BITS-1:0] COS_ONE = FLOAT_BITS'(1) <<< FRAC_BITS;

  logic signed [FLOAT_BITS-1:0] cos_val;
  logic [PIXLW-1:0]             pix;
  logic [PIXLW-1:0]             render_d;

  assign ang_prev = (ang == A_MIN) ? A_MAX : ang - INT_BITS'(1);
  assign ang_next = (ang == A_MAX) ? A_MIN : ang + INT_BITS'(1);

  angle_color_unit_cos_quarter_rom u_cos_rom (
    .ang     (ang),
    .cos_val (cos_val)
  );

  always_comb begin
    pix = palette(sx[6:1], sy[6:1]);
    if (sx >= PICK || sy >= PICK) render_d = '0;
    else if (sx == cx || sy == cy) render_d = ~pix;
    else render_d = pix;
  end

  // Decrement wins when both requests arrive in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      ang     <= '0;
      cos_out <= COS_ONE;
      color   <= '0;
      render  <= '0;
    end else begin
      if (ang_dec) ang <= ang_prev;
      else if (ang_inc) ang <= ang_next;
      cos_out <= cos_val;
      color   <= palette(cx[6:1], cy[6:1]);
      render  <= render_d;
    end
  end

endmodule

// File: tb/tb_angle_color_unit.sv
// Self-checking bench for angle_color_unit: behavioural reference model with
// per-cycle compare, directed boundary checks and randomized stimulus.
module tb_angle_color_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic               ang_dec, ang_inc;
  logic signed [15:0] ang, ang_prev, ang_next;
  logic signed [31:0] cos_out;
  logic [15:0]        cx, cy, sx, sy;
  logic [11:0]        color, render;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int m_ang, m_cos, m_color, m_render;

  angle_color_unit dut (
    .clk(clk), .rst(rst), .ang_dec(ang_dec), .ang_inc(ang_inc),
    .ang(ang), .ang_prev(ang_prev), .ang_next(ang_next), .cos_out(cos_out),
    .cx(cx), .cy(cy), .sx(sx), .sy(sy), .color(color), .render(render)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input int a);
    if (a > 179) return a - 360;
    if (a < -180) return a + 360;
    return a;
  endfunction

  function automatic int cos_ref(input int a);
    real r;
    r = 65536.0 * $cos(real'(a) * 3.14159265358979323846 / 180.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int pal_ref(input int x, input int y);
    int xl, yl;
    xl = x % 128;
    yl = y % 128;
    return (xl / 8) * 256 + (yl / 8) * 16 + ((xl % 8) / 2) * 4 + (yl % 8) / 2;
  endfunction

  function automatic int render_ref(input int px, input int py, input int ux, input int uy);
    if (px >= 128 || py >= 128) return 0;
    if (px == ux || py == uy) return 4095 - pal_ref(px, py);
    return pal_ref(px, py);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      m_ang    <= 0;
      m_cos    <= 65536;
      m_color  <= 0;
      m_render <= 0;
    end else begin
      m_ang    <= ang_dec ? wrap(m_ang - 1) : (ang_inc ? wrap(m_ang + 1) : m_ang);
      m_cos    <= cos_ref(m_ang);
      m_color  <= pal_ref(int'(cx), int'(cy));
      m_render <= render_ref(int'(sx), int'(sy), int'(cx), int'(cy));
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      cmp("ang", int'(ang), m_ang);
      cmp("ang_prev", int'(ang_prev), wrap(m_ang - 1));
      cmp("ang_next", int'(ang_next), wrap(m_ang + 1));
      cmp("cos_out", int'(cos_out), m_cos);
      cmp("color", int'(color), m_color);
      cmp("render", int'(render), m_render);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; ang_dec = 1'b0; ang_inc = 1'b0;
    cx = '0; cy = '0; sx = '0; sy = '0;
    check_en = 1'b1;
    cycles(2);
    cmp("reset_ang", int'(ang), 0);
    cmp("reset_cos", int'(cos_out), 32'h0001_0000);
    cmp("reset_color", int'(color), 0);
    cmp("reset_render", int'(render), 0);
    rst = 1'b1;

    ang_inc = 1'b1; cycles(60); ang_inc = 1'b0;
    cmp("inc60_ang", int'(ang), 60);
    cycles(1);
    cmp("inc60_cos", int'(cos_out), 32768);
    ang_inc = 1'b1; cycles(30); ang_inc = 1'b0; cycles(1);
    cmp("inc90_ang", int'(ang), 90);
    cmp("inc90_cos", int'(cos_out), 0);

    do_reset();
    ang_dec = 1'b1; cycles(120); ang_dec = 1'b0; cycles(1);
    cmp("dec120_ang", int'(ang), -120);
    cmp("dec120_cos", int'(cos_out), -32768);
    ang_dec = 1'b1; cycles(60); ang_dec = 1'b0;
    cmp("min_ang", int'(ang), -180);
    cmp("min_prev", int'(ang_prev), 179);
    cmp("min_next", int'(ang_next), -179);
    cycles(1);
    cmp("min_cos", int'(cos_out), -65536);
    ang_dec = 1'b1; cycles(1); ang_dec = 1'b0; cycles(1);
    cmp("wrap_dec_ang", int'(ang), 179);
    cmp("wrap_dec_cos", int'(cos_out), -65526);
    ang_inc = 1'b1; cycles(1); ang_inc = 1'b0;
    cmp("wrap_inc_ang", int'(ang), -180);

    do_reset();
    ang_inc = 1'b1; cycles(1); ang_inc = 1'b0; cycles(1);
    cmp("one_ang", int'(ang), 1);
    cmp("one_cos", int'(cos_out), 65526);

    do_reset();
    ang_inc = 1'b1; ang_dec = 1'b1; cycles(1); ang_inc = 1'b0; ang_dec = 1'b0;
    cmp("both_ang", int'(ang), -1);

    ang_inc = 1'b1; cycles(5);
    rst = 1'b0; cycles(1);
    cmp("midrst_ang", int'(ang), 0);
    cmp("midrst_cos", int'(cos_out), 65536);
    rst = 1'b1; ang_inc = 1'b0;

    cx = 16'd80; cy = 16'd42; sx = 16'd80; sy = 16'd0; cycles(1);
    cmp("pal_color", int'(color), 12'hA51);
    cmp("pal_cross", int'(render), 12'h5FF);
    sx = 16'd10; sy = 16'd3; cycles(1);
    cmp("pal_plain", int'(render), 12'h105);
    sx = 16'd128; sy = 16'd5; cycles(1);
    cmp("pal_outside", int'(render), 12'h000);

    for (int i = 0; i < 4000; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      ang_dec = (sel < 3) || (sel == 9);
      ang_inc = (sel >= 3 && sel < 7) || (sel == 9);
      rst = ($urandom_range(0, 299) != 0);
      cx = 16'($urandom_range(0, 127));
      cy = 16'($urandom_range(0, 127));
      case ($urandom_range(0, 5))
        0: begin sx = cx; sy = 16'($urandom_range(0, 159)); end
        1: begin sy = cy; sx = 16'($urandom_range(0, 159)); end
        2: begin sx = 16'($urandom); sy = 16'($urandom); end
        default: begin sx = 16'($urandom_range(0, 159)); sy = 16'($urandom_range(0, 159)); end
      endcase
      cycles(1);
    end
    rst = 1'b1; ang_dec = 1'b0; ang_inc = 1'b0;
    cycles(2);
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/angle_color_unit.md
# angle_color_unit

Registered helper for the shape editor: holds the selected shape's rotation angle, wrapping it circularly over [-180, 179] degrees on increment/decrement requests, and produces its Q16.16 cosine. It also maps color-picker coordinates to 12-bit palette colors and renders the picker swatch with a crosshair cursor. It sits between the input-mode button logic and the shape pre-processor / VGA pixel mux.

## Interface
Clocking: one clock; reset is synchronous and active-low.

Parameters:
- INT_BITS, 16, integer/angle/coordinate width
- FLOAT_BITS, 32, fixed-point width (Q16.16)
- FRAC_BITS, 16, fractional bits of fixed-point values
- PIXLW, 12, RGB444 color width
- ANG_MIN, -180, lowest angle
- ANG_MAX, 179, highest angle
- PICK_SIZE, 128, palette side length in pixels (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- ang_dec  in  1  decrement angle by 1 this cycle
- ang_inc  in  1  increment angle by 1 this cycle
- ang  out  INT_BITS signed  current angle register
- ang_prev  out  INT_BITS signed  combinational circular predecessor of ang
- ang_next  out  INT_BITS signed  combinational circular successor of ang
- cos_out  out  FLOAT_BITS signed  registered cos(ang), Q16.16
- cx, cy  in  INT_BITS  picker cursor coordinates
- sx, sy  in  INT_BITS  pixel coordinates relative to the picker origin
- color  out  PIXLW  registered palette color under the cursor
- render  out  PIXLW  registered picker pixel color at (sx, sy)

## Operation
- Circular step:
  - ang_prev = (ang == ANG_MIN) ? ANG_MAX : ang-1
  - ang_next = (ang == ANG_MAX) ? ANG_MIN : ang+1
- Angle update per cycle:
  - ang_dec -> ang <= ang_prev
  - else ang_inc -> ang <= ang_next
  - else hold
  - ang_dec has priority when both are high.
- Cosine:
  - a = |ang|
  - a <= 90 -> +T[a]; otherwise -T[180-a]
  - T[k] = round(65536*cos(k°)), k = 0..90; T[0] = 65536, T[90] = 0.
  - Result is sign-extended to FLOAT_BITS.
- Palette function P(x, y), using the low 7 bits of each coordinate: R = x[6:3], G = y[6:3], B = {x[2:1], y[2:1]}; output {R, G, B}.
- color = P(cx, cy).
- render:
  - sx or sy >= PICK_SIZE (unsigned) -> 12'h000
  - else (sx == cx) or (sy == cy) -> ~P(sx, sy) (crosshair)
  - else P(sx, sy)

## Timing
- Reset (rst = 0 at a clock edge): ang = 0, cos_out = 32'h0001_0000, color = 0, render = 0. Reset overrides ang_inc/ang_dec.
- ang updates on the edge where a request is sampled.
- ang_prev/ang_next follow ang combinationally.
- cos_out is recomputed from the registered ang every cycle, so it lags ang by exactly 1 cycle.
- color/render: 1-cycle latency from cx, cy, sx, sy; no handshake.
- Wrap boundaries:
  - inc at 179 -> -180
  - dec at -180 -> 179
  - holding a request steps once per cycle.
- Reset asserted mid-sequence takes effect at the next edge; the first post-reset cos_out is 65536.

## Structure
- Shared package (e.g. fixed_pkg):
  - INT_BITS, FLOAT_BITS, FRAC_BITS
  - the 91-entry quarter-wave cosine table as a localparam array
- One natural sub-module: cos_quarter_rom (combinational, signed angle in -> signed Q16.16 out) containing the abs/fold logic and the table.
- Circular step and palette logic stay inline.

## Test plan
- Reset, then 60 cycles of ang_inc -> ang = 60; cos_out = 32768 one cycle later. Continue to ang = 90 -> cos_out = 0.
- From reset, 120 cycles of ang_dec -> ang = -120, cos_out = -32768. Then 60 more ang_dec -> ang = -180, cos_out = -65536, ang_prev = 179, ang_next = -179.
- One further ang_dec at -180 -> ang = 179 (cos_out = -65526). Then one ang_inc -> ang = -180. One ang_inc at ang = 0 -> ang = 1, cos_out = 65526.
- ang_inc and ang_dec high together at ang = 0 -> ang = -1. Reset asserted during a stream of ang_inc -> ang = 0, cos_out = 65536 (32'h0001_0000).
- Palette checks with cx = 80, cy = 42:
  - color = 12'hA51
  - (sx, sy) = (80, 0) -> render 12'h5FF (crosshair)
  - (10, 3) -> 12'h105
  - (128, 5) -> 12'h000
  - each one cycle after the inputs are applied.
